ntt_ld_streamer: RTL and testbench



---
 rtl/ntt_ld_streamer_pkg.sv | 24 ++
 rtl/ntt_ld_streamer_if.sv | 26 ++
 rtl/ntt_coef_packer.sv | 59 +++++
 rtl/ntt_ld_streamer.sv | 131 +++++++++++++
 tb/tb_ntt_ld_streamer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_ld_streamer_pkg.sv
// Shared constants, FSM state type and beat-to-word mapping for the NTT load streamer.
// Latency: none (definitions only); backpressure: n/a.
package ntt_stream_pkg;

    localparam int COEF_W     = 16;
    localparam int LANES      = 8;
    localparam int N_COEF     = 1024;
    localparam int N_BEATS    = 128;
    localparam int HALF_WORDS = 64;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SEND
    } state_t;

    // Even beats walk the low half of the polynomial, odd beats the high half.
    function automatic logic [6:0] beat_to_idx(input logic [6:0] beat);
        logic [6:0] half;
        half = {1'b0, beat[6:1]};
        return beat[0] ? (7'(HALF_WORDS) + half) : half;
    endfunction

endpackage

// File: rtl/ntt_ld_streamer_if.sv
// Coefficient input stream plus kernel load port, bundled for the streamer.
// Latency: none; backpressure: s_rdy on the input side, ld_rdy on the load side.
interface ntt_ld_streamer_if #(
    parameter int pDATA_WIDTH = 128,
    parameter int pCOEF_WIDTH = 16
);

    logic                   s_vld;
    logic                   s_rdy;
    logic [pCOEF_WIDTH-1:0] s_dat;
    logic                   ld_vld;
    logic                   ld_rdy;
    logic [pDATA_WIDTH-1:0] ld_dat;
    logic                   ld_lst;

    modport master (
        input  s_vld, s_dat, ld_rdy,
        output s_rdy, ld_vld, ld_dat, ld_lst
    );

    modport slave (
        input  s_rdy, ld_vld, ld_dat, ld_lst,
        output s_vld, s_dat, ld_rdy
    );

endinterface

// File: rtl/ntt_coef_packer.sv
// Packs accepted coefficients into full buffer words; the 8th coefficient completes a word.
// Latency: write strobe in the same cycle as the completing accept; backpressure: none (follows acc).
module ntt_coef_packer #(
    parameter int pCOEF_WIDTH = 16,
    parameter int pLANES      = 8,
    parameter int pWORDS      = 128
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            acc,
    input  logic [pCOEF_WIDTH-1:0]          dat,
    output logic                            wr_en,
    output logic [$clog2(pWORDS)-1:0]       wr_idx,
    output logic [pCOEF_WIDTH*pLANES-1:0]   wr_word,
    output logic                            last
);

    localparam int LW = $clog2(pLANES);
    localparam int IW = $clog2(pWORDS);

    logic [LW-1:0]          lane_q;
    logic [IW-1:0]          word_q;
    logic [pCOEF_WIDTH-1:0] pack_q [pLANES];
    logic                   lane_end;

    assign lane_end = (lane_q == LW'(pLANES - 1));

    // {word_q, lane_q} is the 10-bit coefficient counter; it wraps to 0 after a full frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (acc) begin
            lane_q <= lane_q + LW'(1);
            if (lane_end) begin
                word_q <= word_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            pack_q[lane_q] <= dat;
        end
    end

    // Top lane comes straight from the live input so the word is written without an extra cycle.
    always_comb begin
        wr_word = '0;
        for (int j = 0; j < pLANES; j++) begin
            wr_word[j*pCOEF_WIDTH +: pCOEF_WIDTH] = (j == pLANES - 1) ? dat : pack_q[j];
        end
    end

    assign wr_en  = acc && lane_end;
    assign wr_idx = word_q;
    assign last   = wr_en && (word_q == IW'(pWORDS - 1));

endmodule

// File: rtl/ntt_ld_streamer.sv
// Buffers one natural-order polynomial, then streams it to the kernel in low/high interleaved order.
// Latency: beat 0 two cycles after the last coefficient; backpressure: ld_rdy stalls the output register, s_rdy low while sending.
module ntt_ld_streamer
    import ntt_stream_pkg::*;
#(
    parameter int pDATA_WIDTH = 128,
    parameter int pCOEF_WIDTH = 16,
    parameter int pN          = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    ntt_ld_streamer_if.master bus,
    output logic              busy,
    output logic              done
);

    localparam int LANES_P = pDATA_WIDTH / pCOEF_WIDTH;
    localparam int WORDS_P = pN / LANES_P;
    localparam int IDX_W   = $clog2(WORDS_P);
    localparam int BEAT_W  = IDX_W + 1;

    state_t state_q;
    state_t state_d;

    logic                   acc;
    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic [pDATA_WIDTH-1:0] wr_word;
    logic                   fill_last;

    logic [pDATA_WIDTH-1:0] buf_mem [WORDS_P];
    logic [IDX_W-1:0]       rd_idx;

    logic [BEAT_W-1:0]      beat_q;
    logic                   beats_left;
    logic                   ld_vld_q;
    logic [pDATA_WIDTH-1:0] ld_dat_q;
    logic                   ld_lst_q;
    logic                   hs;
    logic                   frame_end;

    assign acc = bus.s_vld && bus.s_rdy;

    ntt_coef_packer #(
        .pCOEF_WIDTH (pCOEF_WIDTH),
        .pLANES      (LANES_P),
        .pWORDS      (WORDS_P)
    ) u_packer (
        .clk     (clk),
        .rstn    (rstn),
        .acc     (acc),
        .dat     (bus.s_dat),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_word (wr_word),
        .last    (fill_last)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_idx] <= wr_word;
        end
    end

    assign rd_idx     = IDX_W'(beat_to_idx(7'(beat_q[IDX_W-1:0])));
    assign beats_left = (beat_q < BEAT_W'(WORDS_P));
    assign hs         = ld_vld_q && bus.ld_rdy;
    assign frame_end  = hs && ld_lst_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus.s_rdy = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: state_d = FILL;
            FILL: begin
                bus.s_rdy = 1'b1;
                if (fill_last) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (frame_end) begin
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register only advances when empty or when the current beat is taken.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ld_vld_q <= 1'b0;
            ld_dat_q <= '0;
            ld_lst_q <= 1'b0;
            beat_q   <= '0;
            done     <= 1'b0;
        end else begin
            done <= frame_end;
            if (state_q == SEND && (!ld_vld_q || bus.ld_rdy)) begin
                if (beats_left) begin
                    ld_vld_q <= 1'b1;
                    ld_dat_q <= buf_mem[rd_idx];
                    ld_lst_q <= (beat_q == BEAT_W'(WORDS_P - 1));
                    beat_q   <= beat_q + BEAT_W'(1);
                end else begin
                    ld_vld_q <= 1'b0;
                    ld_lst_q <= 1'b0;
                end
            end
            if (frame_end) begin
                beat_q <= '0;
            end
        end
    end

    assign bus.ld_vld = ld_vld_q;
    assign bus.ld_dat = ld_dat_q;
    assign bus.ld_lst = ld_lst_q;

endmodule

// File: tb/tb_ntt_ld_streamer.sv
// Directed bench for ntt_ld_streamer: expected beats are queued when a frame is fed and checked on handshake.
module tb_ntt_ld_streamer;

    logic clk = 1'b0;
    logic rstn;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    ntt_ld_streamer_if #(.pDATA_WIDTH(128), .pCOEF_WIDTH(16)) bus ();

    ntt_ld_streamer #(
        .pDATA_WIDTH (128),
        .pCOEF_WIDTH (16),
        .pN          (1024)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    bit            in_reset = 1'b1;
    int            hs_total = 0;
    int            base = 0;
    logic [128:0]  exp_q [$];
    logic [15:0]   frame [1024];
    logic [127:0]  got [2048];
    int            hs_cyc [2048];
    bit            prev_stall = 1'b0;
    logic [127:0]  prev_dat;
    logic          prev_lst;
    logic [128:0]  e_pop;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ld_rdy pattern: 0 = always ready, 1 = one pulse every 8 cycles
    initial begin
        bus.ld_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.ld_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 8) == 0);
        end
    end

    // Scoreboard, stability and s_rdy-during-SEND monitor
    always @(negedge clk) begin
        if (in_reset || !rstn) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (busy) chk("s_rdy_in_send", {127'd0, bus.s_rdy}, 128'd0);
            if (prev_stall) begin
                chk("hold_vld", {127'd0, bus.ld_vld}, 128'd1);
                chk("hold_dat", bus.ld_dat, prev_dat);
                chk("hold_lst", {127'd0, bus.ld_lst}, {127'd0, prev_lst});
            end
            if (bus.ld_vld && bus.ld_rdy) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed=%0h expected=none", bus.ld_dat);
                end
                if (exp_q.size() != 0) begin
                    e_pop = exp_q.pop_front();
                    chk("beat_dat", bus.ld_dat, e_pop[127:0]);
                    chk("beat_lst", {127'd0, bus.ld_lst}, {127'd0, e_pop[128]});
                end
                got[hs_total % 2048]    = bus.ld_dat;
                hs_cyc[hs_total % 2048] = cyc;
                hs_total++;
            end
            prev_stall = bus.ld_vld && !bus.ld_rdy;
            prev_dat   = bus.ld_dat;
            prev_lst   = bus.ld_lst;
        end
    end

    task automatic fill_ramp(input logic [15:0] off);
        for (int i = 0; i < 1024; i++) frame[i] = off + 16'(i);
    endtask

    task automatic push_expected();
        int idx;
        logic [128:0] e;
        for (int b = 0; b < 128; b++) begin
            idx = (b % 2 == 0) ? b / 2 : 64 + (b - 1) / 2;
            e = '0;
            e[128] = (b == 127);
            for (int j = 0; j < 8; j++) e[16*j +: 16] = frame[idx*8 + j];
            exp_q.push_back(e);
        end
    endtask

    task automatic feed(input int n, input bit gaps);
        int  k = 0;
        int  guard = 0;
        bit  acc;
        while (k < n && guard < 6000) begin
            bus.s_vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.s_dat = bus.s_vld ? frame[k] : 16'hBEEF;
            acc = bus.s_vld && bus.s_rdy;
            @(posedge clk);
            #1;
            guard++;
            if (acc) k++;
        end
        chk("feed_count", 128'(k), 128'(n));
        // junk offered while sending must be ignored
        bus.s_vld = gaps;
        bus.s_dat = 16'hDEAD;
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 4000) begin
            @(negedge clk);
            if (bus.ld_vld && bus.ld_lst) bus.s_vld = 1'b0;
            g++;
        end
        bus.s_vld = 1'b0;
        chk("done_seen", {127'd0, done}, 128'd1);
        chk("end_vld", {127'd0, bus.ld_vld}, 128'd0);
        chk("end_lst", {127'd0, bus.ld_lst}, 128'd0);
        chk("end_s_rdy", {127'd0, bus.s_rdy}, 128'd1);
        chk("end_busy", {127'd0, busy}, 128'd0);
        chk("end_queue", 128'(exp_q.size()), 128'd0);
        @(negedge clk);
        chk("done_pulse", {127'd0, done}, 128'd0);
    endtask

    task automatic run_frame(input bit gaps);
        base = hs_total;
        push_expected();
        feed(1024, gaps);
        @(negedge clk);
        chk("lat_busy", {127'd0, busy}, 128'd1);
        chk("lat_s_rdy", {127'd0, bus.s_rdy}, 128'd0);
        chk("lat_vld_t1", {127'd0, bus.ld_vld}, 128'd0);
        @(negedge clk);
        chk("lat_vld_t2", {127'd0, bus.ld_vld}, 128'd1);
        wait_done();
    endtask

    task automatic do_reset();
        bus.s_vld = 1'b0;
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_vld", {127'd0, bus.ld_vld}, 128'd0);
        chk("rst_lst", {127'd0, bus.ld_lst}, 128'd0);
        chk("rst_dat", bus.ld_dat, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_s_rdy", {127'd0, bus.s_rdy}, 128'd0);
        in_reset = 1'b0;
        @(negedge clk);
        chk("rst_s_rdy_fill", {127'd0, bus.s_rdy}, 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rstn = 1'b0;
        bus.s_vld = 1'b0;
        bus.s_dat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("por_vld", {127'd0, bus.ld_vld}, 128'd0);
        chk("por_dat", bus.ld_dat, 128'd0);
        chk("por_lst", {127'd0, bus.ld_lst}, 128'd0);
        chk("por_busy", {127'd0, busy}, 128'd0);
        chk("por_done", {127'd0, done}, 128'd0);
        chk("por_s_rdy", {127'd0, bus.s_rdy}, 128'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        in_reset = 1'b0;
        @(negedge clk);
        chk("idle_s_rdy", {127'd0, bus.s_rdy}, 128'd0);
        @(negedge clk);
        chk("fill_s_rdy", {127'd0, bus.s_rdy}, 128'd1);

        // ramp with ld_rdy held high
        rdy_mode = 0;
        fill_ramp(16'h0000);
        run_frame(1'b0);
        chk("ramp_beat0", got[base % 2048], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        chk("ramp_beat1", got[(base + 1) % 2048], 128'h0207_0206_0205_0204_0203_0202_0201_0200);
        chk("ramp_beat127", got[(base + 127) % 2048], 128'h03FF_03FE_03FD_03FC_03FB_03FA_03F9_03F8);
        chk("ramp_thruput", 128'(hs_cyc[(base + 127) % 2048] - hs_cyc[base % 2048]), 128'd127);

        // back-to-back frame
        fill_ramp(16'h1000);
        run_frame(1'b0);
        chk("b2b_beat0", got[base % 2048], 128'h1007_1006_1005_1004_1003_1002_1001_1000);

        // kernel-paced backpressure
        rdy_mode = 1;
        fill_ramp(16'h0000);
        run_frame(1'b0);
        chk("bp_beat0", got[base % 2048], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        chk("bp_pace", 128'(hs_cyc[(base + 127) % 2048] - hs_cyc[base % 2048]), 128'd1016);

        // random data, input gaps, junk offered during SEND
        rdy_mode = 0;
        for (int i = 0; i < 1024; i++) frame[i] = 16'($urandom);
        run_frame(1'b1);

        // reset mid-SEND around beat 40
        fill_ramp(16'h0000);
        base = hs_total;
        push_expected();
        feed(1024, 1'b0);
        g = 0;
        while (hs_total < base + 40 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("send_reached_40", 128'(hs_total >= base + 40), 128'd1);
        do_reset();
        run_frame(1'b0);
        chk("post_send_rst_beat0", got[base % 2048], 128'h0007_0006_0005_0004_0003_0002_0001_0000);

        // reset mid-FILL after 300 coefficients
        fill_ramp(16'h5000);
        feed(300, 1'b0);
        do_reset();
        fill_ramp(16'h0000);
        run_frame(1'b0);
        chk("post_fill_rst_beat0", got[base % 2048], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        chk("post_fill_rst_beat127", got[(base + 127) % 2048], 128'h03FF_03FE_03FD_03FC_03FB_03FA_03F9_03F8);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
